uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the SoC UART link: accepts bytes from the core/GPIO side through a small FIFO and shifts them out on `uart_txd` as 8N1 frames (start, LSB-first payload, optional parity, stop). Sits beside the UART receiver in `wrapper`, uses the same bit-rate and clock parameters, and must interoperate with that receiver bit-exactly for loopback and status reporting (e.g. `write_done` acknowledgements after instruction-memory loading).

## Interface
- `BIT_RATE`, 9600, line rate in bits/s
- `CLK_HZ`, 50000000, frequency of `clk` in Hz
- `PAYLOAD_BITS`, 8, data bits per frame
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `FIFO_DEPTH`, 4, transmit FIFO entries (power of two, ≥2)

- `clk` in 1, system clock
- `resetn` in 1, asynchronous active-low reset
- `uart_tx_en` in 1, write strobe; byte accepted on a rising `clk` edge when `uart_tx_en && uart_tx_ready`
- `uart_tx_data` in PAYLOAD_BITS, byte to send; sampled with `uart_tx_en`
- `uart_tx_ready` out 1, FIFO not full
- `uart_tx_busy` out 1, FIFO non-empty or frame in progress
- `uart_txd` out 1, serial line, registered, idle high

## Operation
- `CYCLES_PER_BIT = CLK_HZ / BIT_RATE` (integer division; 5208 at defaults). Bit counter width `$clog2(CYCLES_PER_BIT)`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: `uart_txd`=1. If FIFO non-empty: pop head into shift register, go START.
  - START: `uart_txd`=0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA: `uart_txd`=shift[0], shift right each bit period; after PAYLOAD_BITS periods go PARITY or STOP.
  - STOP: `uart_txd`=1 for STOP_BITS×CYCLES_PER_BIT cycles; then if FIFO non-empty pop and go START directly (no idle gap), else IDLE.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH, count of width `$clog2(FIFO_DEPTH)+1`. Write when full (`uart_tx_ready`=0) is ignored, data dropped, no error flag. Simultaneous push and pop allowed when non-full and non-empty; count unchanged.
- Push into empty FIFO while IDLE: byte is popped on the next edge; no bypass path.
- `uart_tx_busy` = (state≠IDLE) || (count≠0).

## Timing
- Reset (async assert, sync-clean deassert by system): `uart_txd`=1, `uart_tx_ready`=1, `uart_tx_busy`=0, FIFO empty, state IDLE, counters 0. Reset mid-frame aborts the frame immediately; line returns high without completing the stop bit.
- Push accepted at edge k (FIFO empty, IDLE): `uart_tx_busy`=1 after edge k; pop and START entry at edge k+1; `uart_txd` falls after edge k+1.
- Every bit, including each stop bit, lasts exactly CYCLES_PER_BIT cycles; frame = (1+PAYLOAD_BITS+parity+STOP_BITS)×CYCLES_PER_BIT cycles.
- `uart_tx_ready` deasserts the cycle after the write filling the FIFO; reasserts the cycle after the pop that frees an entry.
- `uart_tx_busy` falls on the edge the last stop bit ends with FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after DATA, one bit period, even parity (XOR of payload bits); frame grows by CYCLES_PER_BIT. Paired receiver must be built with matching parity.
- Undefined: no PARITY state, 8N1 framing only; no parity logic synthesised.

## Structure
- Shared `uart_pkg`: FSM state enum, `cycles_per_bit(clk_hz, bit_rate)` function, defaults for BIT_RATE/CLK_HZ shared with the receiver.
- One sub-module: `uart_tx_fifo` (parameter FIFO_DEPTH, WIDTH; push/pop/full/empty/count), same clock and async active-low reset.

## Test plan
- Reset: hold `resetn`=0 for 4000 ns -> `uart_txd`=1, `uart_tx_ready`=1, `uart_tx_busy`=0.
- Single byte 8'h13 at defaults -> line sequence 0,1,1,0,0,1,0,0,0,1, each held 5208 cycles; `uart_tx_busy` drops at end of stop bit.
- Burst 8'h13,8'h00,8'h00,8'h00 (instruction 32'h00000013 LSB byte first) -> four contiguous frames, no idle gap; looped to receiver, `uart_rx_data` matches each byte, 4 passes/0 fails.
- Write 6 bytes back-to-back while first frame in progress, FIFO_DEPTH=4 -> `uart_tx_ready` low after 5th accepted write (1 in shift reg + 4 queued), 6th dropped; exactly 5 frames on line.
- Assert `resetn`=0 during DATA bit 3 of 8'hA5 -> `uart_txd`=1 immediately, FIFO empty, no further frames after release.
- With `UART_TX_PARITY_EN`, send 8'h07 -> parity bit 1 after payload; send 8'h03 -> parity bit 0; frame length 11×5208 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Definitions shared by the UART transmitter and receiver so that both sides
// agree on bit timing and framing.
//   DEFAULT_BIT_RATE / DEFAULT_CLK_HZ : default line rate and system clock
//   tx_state_t                        : transmitter FSM states
//   cycles_per_bit()                  : clock cycles per serial bit
package uart_pkg;

  localparam int DEFAULT_BIT_RATE = 9600;
  localparam int DEFAULT_CLK_HZ   = 50_000_000;

  // ST_PARITY is only entered when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Integer division: the receiver uses the same rounding, so both ends
  // drift identically against the nominal rate.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
// Small circular FIFO holding bytes waiting to be serialised.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write request (ignored when full, data dropped)
//   push_data   : data written on an accepted push
//   pop         : read request (ignored when empty)
//   head        : oldest entry, valid while !empty
//   full, empty : occupancy flags derived from count
//   count       : number of stored entries (0..FIFO_DEPTH)
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The head is read combinationally so the FSM can load it on the same edge
  // it pops, which gives the one-cycle push-to-start latency.
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx
// UART transmitter: bytes enter through a small FIFO and leave on uart_txd
// as start bit, LSB-first payload, optional even parity, stop bit(s).
// Optional feature: define UART_TX_PARITY_EN to add an even parity bit after
// the payload; otherwise frames are 8N1 and no parity logic exists.
//   clk, resetn   : clock, asynchronous active-low reset
//   uart_tx_en    : write strobe, accepted when uart_tx_ready is high
//   uart_tx_data  : byte written with uart_tx_en
//   uart_tx_ready : FIFO has room
//   uart_tx_busy  : FIFO non-empty or a frame is on the line
//   uart_txd      : registered serial output, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = DEFAULT_BIT_RATE,
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W  = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IDX_W  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t               state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic                    stop_idx;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [PAYLOAD_BITS-1:0] shift_next;
`ifdef UART_TX_PARITY_EN
  logic                    parity_reg;
`endif

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] fifo_head;
  logic [FCNT_W-1:0]       fifo_count;
  logic                    bit_end;
  logic                    last_stop;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (PAYLOAD_BITS)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (uart_tx_en),
    .push_data (uart_tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_end    = (bit_cnt == CNT_LAST);
  assign last_stop  = (state == ST_STOP) && bit_end && (stop_idx == STOP_LAST);
  assign shift_next = shift_reg >> 1;

  // Pop either from idle or on the final stop-bit edge, so queued bytes
  // follow each other with no idle gap on the line.
  assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || last_stop);

  assign uart_tx_ready = !fifo_full;
  assign uart_tx_busy  = (state != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      uart_txd  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          uart_txd <= 1'b1;
          if (fifo_pop) begin
            shift_reg <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^fifo_head;
`endif
            bit_cnt  <= '0;
            state    <= ST_START;
            uart_txd <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            uart_txd <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state    <= ST_PARITY;
              uart_txd <= parity_reg;
`else
              state    <= ST_STOP;
              stop_idx <= 1'b0;
              uart_txd <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_next;
              uart_txd  <= shift_next[0];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            state    <= ST_STOP;
            uart_txd <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              if (fifo_pop) begin
                shift_reg <= fifo_head;
`ifdef UART_TX_PARITY_EN
                parity_reg <= ^fifo_head;
`endif
                state    <= ST_START;
                uart_txd <= 1'b0;
              end else begin
                state    <= ST_IDLE;
                uart_txd <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx
// Self-checking bench for uart_tx, run at 16 clocks per bit to keep frames
// short. A frame-level reference model predicts uart_txd, uart_tx_busy and
// uart_tx_ready every cycle; a line decoder recovers bytes from uart_txd and
// compares them with the bytes the model says were accepted.
// Honours UART_TX_PARITY_EN to expect the parity bit.
module tb_uart_tx;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 62_500;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = 1 + 8 + PAR + 1;
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_tx_en = 1'b0;
  logic [7:0] uart_tx_data = 8'h00;
  logic       uart_tx_ready;
  logic       uart_tx_busy;
  logic       uart_txd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .BIT_RATE     (BIT_RATE),
    .CLK_HZ       (CLK_HZ),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_busy  (uart_tx_busy),
    .uart_txd      (uart_txd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level of bit k (0 = start) of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] q_model[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  int         cyc = 0;
  int         cur_start = 0;
  int         free_at = 0;
  logic [7:0] cur_byte = 8'h00;
  bit         have_frame = 1'b0;

  always @(posedge clk) begin : model
    int   size_before;
    bit   in_frame;
    logic e_txd;
    cyc++;
    if (!resetn) begin
      q_model.delete();
      have_frame = 1'b0;
      free_at = 0;
    end else begin
      size_before = q_model.size();
      // A queued byte starts a frame as soon as the line is free.
      if (size_before > 0 && cyc >= free_at) begin
        cur_byte   = q_model.pop_front();
        cur_start  = cyc;
        free_at    = cyc + FRAME;
        have_frame = 1'b1;
      end
      if (uart_tx_en && size_before < DEPTH) begin
        q_model.push_back(uart_tx_data);
        acc_q.push_back(uart_tx_data);
      end
    end
    #1;
    in_frame = have_frame && (cyc < cur_start + FRAME);
    e_txd = in_frame ? frame_bit(cur_byte, (cyc - cur_start) / CPB) : 1'b1;
    chk($sformatf("txd@%0d", cyc), uart_txd, e_txd);
    chk($sformatf("busy@%0d", cyc), uart_tx_busy, in_frame || q_model.size() > 0);
    chk($sformatf("ready@%0d", cyc), uart_tx_ready, q_model.size() < DEPTH);
  end

  // ---------------- line decoder ----------------
  bit         mon_active = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin : line_decoder
    int k;
    if (!resetn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc = 0;
        mon_byte = 8'h00;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc % CPB == CPB / 2) begin
        k = mon_cyc / CPB;
        if (k >= 1 && k <= 8) mon_byte[k-1] = uart_txd;
        if (k == NB - 1) begin
          chk("rx_stop_bit", uart_txd, 1'b1);
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (uart_tx_busy !== 1'b0 && n < 20 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uart_tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, uart_tx_busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_one(input logic [7:0] b);
    @(negedge clk);
    uart_tx_en = 1'b1;
    uart_tx_data = b;
    @(negedge clk);
    uart_tx_en = 1'b0;
  endtask

  task automatic compare_rx(input string tag);
    logic [7:0] a;
    logic [7:0] r;
    chk({tag, "_count"}, rx_q.size(), acc_q.size());
    while (acc_q.size() > 0 && rx_q.size() > 0) begin
      a = acc_q.pop_front();
      r = rx_q.pop_front();
      $display("%s: line byte %02h, written byte %02h", tag, r, a);
      chk({tag, "_byte"}, r, a);
    end
    acc_q.delete();
    rx_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // start, b0..b7, stop; leftmost bit first on line
    logic       par;     // even parity of data
  } vec_t;
  vec_t vecs[8];

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    int   off;
    int   bcnt;
    int   lows;
    logic expb;
    logic [7:0] burst[4];

    vecs[0] = '{8'h13, 10'b0110010001, 1'b1};
    vecs[1] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[2] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[3] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[4] = '{8'h80, 10'b0000000011, 1'b1};
    vecs[5] = '{8'h01, 10'b0100000001, 1'b1};
    vecs[6] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[7] = '{8'h03, 10'b0110000001, 1'b0};
    burst[0] = 8'h13; burst[1] = 8'h00; burst[2] = 8'h00; burst[3] = 8'h00;

    // Reset
    #4000;
    chk("reset_txd", uart_txd, 1'b1);
    chk("reset_ready", uart_tx_ready, 1'b1);
    chk("reset_busy", uart_tx_busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Single frames from the table, bit-by-bit at mid-bit plus end of frame
    for (int v = 0; v < 8; v++) begin
      wait_idle("vec_idle");
      send_one(vecs[v].data);
      chk($sformatf("vec%0d_busy_after_push", v), uart_tx_busy, 1'b1);
      chk($sformatf("vec%0d_line_high_before_start", v), uart_txd, 1'b1);
      @(negedge clk);
      off = 0;
      for (int j = 0; j < NB; j++) begin
        while (off < j * CPB + CPB / 2) begin
          @(negedge clk);
          off++;
        end
        if (j <= 8) expb = vecs[v].frame[9-j];
        else if (PAR == 1 && j == 9) expb = vecs[v].par;
        else expb = 1'b1;
        chk($sformatf("vec%0d_bit%0d", v, j), uart_txd, expb);
      end
      while (off < FRAME - 1) begin
        @(negedge clk);
        off++;
      end
      chk($sformatf("vec%0d_busy_last_cycle", v), uart_tx_busy, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after_stop", v), uart_tx_busy, 1'b0);
      $display("vector %0d: data=%02h sent", v, vecs[v].data);
    end
    wait_idle("table_drain");
    compare_rx("table");

    // Burst of four: contiguous frames, busy spans exactly 4 frames + 1
    @(negedge clk);
    uart_tx_en = 1'b1;
    uart_tx_data = burst[0];
    bcnt = 0;
    for (int i = 1; i < 6 * FRAME; i++) begin
      @(negedge clk);
      if (i < 4) uart_tx_data = burst[i];
      else uart_tx_en = 1'b0;
      if (uart_tx_busy) bcnt++;
      else break;
    end
    chk("burst_busy_cycles", bcnt, 4 * FRAME + 1);
    wait_idle("burst_drain");
    chk("burst_frames", rx_q.size(), 4);
    compare_rx("burst");

    // Six back-to-back writes: the sixth finds the FIFO full and is dropped
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fill_ready_before_write%0d", i), uart_tx_ready, (i == 5) ? 1'b0 : 1'b1);
      uart_tx_en = 1'b1;
      uart_tx_data = 8'h40 + 8'(i);
    end
    @(negedge clk);
    uart_tx_en = 1'b0;
    wait_idle("overflow_drain");
    chk("overflow_frames", rx_q.size(), 5);
    compare_rx("overflow");

    // Randomised traffic: light load, then heavy load with overflow
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      uart_tx_en = ($urandom_range(0, 99) < ((i < 2000) ? 3 : 60));
      uart_tx_data = 8'($urandom);
    end
    @(negedge clk);
    uart_tx_en = 1'b0;
    wait_idle("random_drain");
    compare_rx("random");

    // Reset in the middle of data bit 3 of 8'hA5
    send_one(8'hA5);
    @(negedge clk);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("midframe_txd_before_reset", uart_txd, 1'b0);
    chk("midframe_busy_before_reset", uart_tx_busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midframe_txd_in_reset", uart_txd, 1'b1);
    chk("midframe_ready_in_reset", uart_tx_ready, 1'b1);
    chk("midframe_busy_in_reset", uart_tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    acc_q.delete();
    rx_q.delete();
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    chk("post_reset_low_cycles", lows, 0);
    chk("post_reset_busy", uart_tx_busy, 1'b0);
    compare_rx("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
